// File: rtl/ps2_mouse_pkg.sv
// Shared state encoding and PS/2 mouse protocol bytes for the mouse sequencer.
package ps2_mouse_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FLUSH     = 4'd1,
    SEND_RST  = 4'd2,
    WAIT_ACK1 = 4'd3,
    WAIT_BAT  = 4'd4,
    WAIT_ID   = 4'd5,
    SEND_EN   = 4'd6,
    WAIT_ACK2 = 4'd7,
    PKT1      = 4'd8,
    PKT2      = 4'd9,
    PKT3      = 4'd10,
    ERR       = 4'd11
  } mouse_state_t;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_STREAM_EN = 8'hF4;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;

endpackage

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse bring-up sequencer and 3-byte movement packet decoder on top of a
// first-word-fall-through RX FIFO and a strobe-driven transmitter.
module ps2_mouse_ctrl
  import ps2_mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int RETRY_MAX      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ps2_rx_data,
  input  logic       ps2_rx_buf_empty,
  output logic       rd_ps2_packet,
  input  logic       ps2_tx_idle,
  output logic       wr_ps2,
  output logic [7:0] ps2_tx_data,
  output logic       init_done,
  output logic       init_err,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic [2:0] btnm,
  output logic       m_done_tick
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  mouse_state_t  r_state, w_state_nxt;
  logic [TW-1:0] r_to_cnt;
  logic [RW-1:0] r_retry, w_retry_nxt;
  logic          r_wr, w_wr_nxt;
  logic [7:0]    r_tx_data, w_tx_data_nxt;
  logic          r_init_done, w_done_nxt;
  logic          r_init_err, w_err_nxt;
  logic [8:0]    r_xm, w_xm_nxt;
  logic [8:0]    r_ym, w_ym_nxt;
  logic [2:0]    r_btn, w_btn_nxt;
  logic          r_tick, w_tick_nxt;
  logic [7:0]    r_b1, w_b1_nxt;
  logic [7:0]    r_b2, w_b2_nxt;
  logic          w_rx_state, w_timed, w_pop, w_timeout, w_fail;

  // A byte present in the cycle the timeout would fire wins over the timeout.
  always_comb begin
    w_rx_state = 1'b0;
    w_timed    = 1'b0;
    case (r_state)
      FLUSH, PKT1: w_rx_state = 1'b1;
      WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2, PKT2, PKT3: begin
        w_rx_state = 1'b1;
        w_timed    = 1'b1;
      end
      default: begin
        w_rx_state = 1'b0;
        w_timed    = 1'b0;
      end
    endcase
    w_pop     = w_rx_state & ~ps2_rx_buf_empty;
    w_timeout = w_timed & ~w_pop & (r_to_cnt == TO_LAST);
  end

  assign rd_ps2_packet = w_pop;

  always_comb begin
    w_state_nxt   = r_state;
    w_retry_nxt   = r_retry;
    w_wr_nxt      = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_done_nxt    = r_init_done;
    w_err_nxt     = r_init_err;
    w_xm_nxt      = r_xm;
    w_ym_nxt      = r_ym;
    w_btn_nxt     = r_btn;
    w_tick_nxt    = 1'b0;
    w_b1_nxt      = r_b1;
    w_b2_nxt      = r_b2;
    w_fail        = 1'b0;
    if (start) begin
      w_state_nxt = FLUSH;
      w_retry_nxt = '0;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        FLUSH: w_state_nxt = ps2_rx_buf_empty ? SEND_RST : FLUSH;
        SEND_RST, SEND_EN: begin
          if (ps2_tx_idle) begin
            w_wr_nxt      = 1'b1;
            w_tx_data_nxt = (r_state == SEND_RST) ? CMD_RESET : CMD_STREAM_EN;
            w_state_nxt   = (r_state == SEND_RST) ? WAIT_ACK1 : WAIT_ACK2;
          end else begin
            w_state_nxt = r_state;
          end
        end
        WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2: begin
          if (w_pop) begin
            case (r_state)
              WAIT_ACK1: if (ps2_rx_data == RSP_ACK) w_state_nxt = WAIT_BAT; else w_fail = 1'b1;
              WAIT_BAT:  if (ps2_rx_data == RSP_BAT_OK) w_state_nxt = WAIT_ID; else w_fail = 1'b1;
              WAIT_ID:   w_state_nxt = SEND_EN;
              default: begin
                if (ps2_rx_data == RSP_ACK) begin
                  w_state_nxt = PKT1;
                  w_done_nxt  = 1'b1;
                end else begin
                  w_fail = 1'b1;
                end
              end
            endcase
          end else begin
            w_fail = w_timeout;
          end
        end
        PKT1: begin
          if (w_pop && ps2_rx_data[3]) begin
            w_b1_nxt    = ps2_rx_data;
            w_state_nxt = PKT2;
          end else begin
            w_state_nxt = PKT1;
          end
        end
        PKT2: begin
          if (w_pop) begin
            w_b2_nxt    = ps2_rx_data;
            w_state_nxt = PKT3;
          end else begin
            w_state_nxt = w_timeout ? PKT1 : PKT2;
          end
        end
        PKT3: begin
          if (w_pop) begin
            w_xm_nxt    = {r_b1[4], r_b2};
            w_ym_nxt    = {r_b1[5], ps2_rx_data};
            w_btn_nxt   = r_b1[2:0];
            w_tick_nxt  = 1'b1;
            w_state_nxt = PKT1;
          end else begin
            w_state_nxt = w_timeout ? PKT1 : PKT3;
          end
        end
        IDLE, ERR: w_state_nxt = r_state;
        default:   w_state_nxt = IDLE;
      endcase
      if (w_fail) begin
        w_retry_nxt = r_retry + RW'(1);
        if (w_retry_nxt < RETRY_LIM) begin
          w_state_nxt = FLUSH;
        end else begin
          w_state_nxt = ERR;
          w_err_nxt   = 1'b1;
        end
      end else begin
        w_retry_nxt = w_retry_nxt;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_retry     <= '0;
      r_wr        <= 1'b0;
      r_tx_data   <= 8'h00;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_xm        <= 9'h000;
      r_ym        <= 9'h000;
      r_btn       <= 3'b000;
      r_tick      <= 1'b0;
      r_b1        <= 8'h00;
      r_b2        <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_retry     <= w_retry_nxt;
      r_wr        <= w_wr_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_init_done <= w_done_nxt;
      r_init_err  <= w_err_nxt;
      r_xm        <= w_xm_nxt;
      r_ym        <= w_ym_nxt;
      r_btn       <= w_btn_nxt;
      r_tick      <= w_tick_nxt;
      r_b1        <= w_b1_nxt;
      r_b2        <= w_b2_nxt;
    end
  end

  // Idle-cycle counter, restarted by any pop or state change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else if (!w_timed || w_pop || (w_state_nxt != r_state)) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  assign wr_ps2      = r_wr;
  assign ps2_tx_data = r_tx_data;
  assign init_done   = r_init_done;
  assign init_err    = r_init_err;
  assign xm          = r_xm;
  assign ym          = r_ym;
  assign btnm        = r_btn;
  assign m_done_tick = r_tick;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Directed + randomized bench for ps2_mouse_ctrl with a mock FWFT RX FIFO and a
// packet-level reference model.
module tb_ps2_mouse_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, ps2_tx_idle;
  logic [7:0] ps2_rx_data;
  logic       ps2_rx_buf_empty, rd_ps2_packet, wr_ps2, init_done, init_err, m_done_tick;
  logic [7:0] ps2_tx_data;
  logic [8:0] xm, ym;
  logic [2:0] btnm;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;

  int         tx_cnt = 0;
  logic [7:0] tx_log [0:63];
  logic       tx_fifo_empty [0:63];
  int         tick_cnt = 0;
  int         tk_x [0:255];
  int         tk_y [0:255];
  int         tk_b [0:255];

  int         ex [0:31];
  int         ey [0:31];
  int         eb [0:31];
  logic [7:0] b1, b2, b3;
  int         base, tbase;

  ps2_mouse_ctrl #(.TIMEOUT_CYCLES(100), .RETRY_MAX(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ps2_rx_data(ps2_rx_data), .ps2_rx_buf_empty(ps2_rx_buf_empty),
    .rd_ps2_packet(rd_ps2_packet), .ps2_tx_idle(ps2_tx_idle),
    .wr_ps2(wr_ps2), .ps2_tx_data(ps2_tx_data),
    .init_done(init_done), .init_err(init_err),
    .xm(xm), .ym(ym), .btnm(btnm), .m_done_tick(m_done_tick)
  );

  always #5 clk = ~clk;

  assign ps2_rx_data      = mem[rd_ptr % 1024];
  assign ps2_rx_buf_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rd_ps2_packet === 1'b1 && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk) begin
    if (wr_ps2 === 1'b1) begin
      tx_log[tx_cnt % 64]        <= ps2_tx_data;
      tx_fifo_empty[tx_cnt % 64] <= ps2_rx_buf_empty;
      tx_cnt                     <= tx_cnt + 1;
    end
    if (m_done_tick === 1'b1) begin
      tk_x[tick_cnt % 256] <= int'($signed(xm));
      tk_y[tick_cnt % 256] <= int'($signed(ym));
      tk_b[tick_cnt % 256] <= int'(btnm);
      tick_cnt             <= tick_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr++;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int b = 0;
    while (tx_cnt < n && b < budget) begin @(negedge clk); b++; end
    chk("tx_wait", 32'(tx_cnt >= n), 32'sd1);
  endtask

  task automatic wait_tick(input int n, input int budget);
    int b = 0;
    while (tick_cnt < n && b < budget) begin @(negedge clk); b++; end
    chk("tick_wait", 32'(tick_cnt >= n), 32'sd1);
  endtask

  task automatic wait_done(input int budget);
    int b = 0;
    while (init_done !== 1'b1 && b < budget) begin @(negedge clk); b++; end
    chk("init_done", 32'(init_done), 32'sd1);
    chk("init_err_clear", 32'(init_err), 32'sd0);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_init();
    int t0 = tx_cnt;
    wait_tx(t0 + 1, 200);
    chk("tx_reset_cmd", 32'(tx_log[t0 % 64]), 32'hFF);
    chk("flushed_before_ff", 32'(tx_fifo_empty[t0 % 64]), 32'sd1);
    @(negedge clk);
    push(8'hFA); push(8'hAA); push(8'($urandom));
    wait_tx(t0 + 2, 200);
    chk("tx_stream_en", 32'(tx_log[(t0 + 1) % 64]), 32'hF4);
    @(negedge clk);
    push(8'hFA);
    wait_done(50);
  endtask

  task automatic packet(input logic [7:0] p1, input logic [7:0] p2, input logic [7:0] p3);
    int t = tick_cnt;
    int x = int'(p2) - (p1[4] ? 256 : 0);
    int y = int'(p3) - (p1[5] ? 256 : 0);
    @(negedge clk);
    push(p1); push(p2); push(p3);
    wait_tick(t + 1, 50);
    repeat (5) @(negedge clk);
    chk("one_tick", tick_cnt, t + 1);
    chk("pkt_x", tk_x[t % 256], x);
    chk("pkt_y", tk_y[t % 256], y);
    chk("pkt_btn", tk_b[t % 256], int'(p1[2:0]));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    reset = 1'b0; start = 1'b0; ps2_tx_idle = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd", 32'(rd_ps2_packet), 32'sd0);
    chk("rst_wr", 32'(wr_ps2), 32'sd0);
    chk("rst_txd", 32'(ps2_tx_data), 32'sd0);
    chk("rst_done", 32'(init_done), 32'sd0);
    chk("rst_err", 32'(init_err), 32'sd0);
    chk("rst_xm", 32'(xm), 32'sd0);
    chk("rst_ym", 32'(ym), 32'sd0);
    chk("rst_btn", 32'(btnm), 32'sd0);
    chk("rst_tick", 32'(m_done_tick), 32'sd0);
    reset = 1'b1;

    // Happy path with stale bytes and a busy transmitter.
    push(8'h12); push(8'hFA); push(8'h77);
    @(negedge clk);
    chk("idle_no_pop", 32'(rd_ps2_packet), 32'sd0);
    ps2_tx_idle = 1'b0;
    pulse_start();
    repeat (20) @(negedge clk);
    chk("tx_gated_by_idle", tx_cnt, 0);
    chk("stale_flushed", 32'(ps2_rx_buf_empty), 32'sd1);
    ps2_tx_idle = 1'b1;
    finish_init();
    chk("two_tx", tx_cnt, 2);

    // Directed packet and resync.
    tbase = tick_cnt;
    packet(8'h39, 8'h05, 8'hF0);
    chk("dir_xm", 32'(xm), 32'h105);
    chk("dir_ym", 32'(ym), 32'h1F0);
    chk("dir_btn", 32'(btnm), 32'sd1);
    @(negedge clk); push(8'h00);
    packet(8'h08, 8'h02, 8'h03);
    chk("resync_xm", 32'(xm), 32'sd2);
    chk("resync_ym", 32'(ym), 32'sd3);
    chk("resync_btn", 32'(btnm), 32'sd0);

    // Randomized packet stream with junk bytes between packets.
    base = tick_cnt;
    @(negedge clk);
    for (int p = 0; p < 20; p++) begin
      int nj = int'($urandom_range(0, 2));
      for (int j = 0; j < nj; j++) push(8'($urandom) & 8'hF7);
      b1 = 8'($urandom) | 8'h08; b2 = 8'($urandom); b3 = 8'($urandom);
      push(b1); push(b2); push(b3);
      ex[p] = int'(b2) - (b1[4] ? 256 : 0);
      ey[p] = int'(b3) - (b1[5] ? 256 : 0);
      eb[p] = int'(b1[2:0]);
    end
    wait_tick(base + 20, 600);
    for (int p = 0; p < 20; p++) begin
      chk("rnd_x", tk_x[(base + p) % 256], ex[p]);
      chk("rnd_y", tk_y[(base + p) % 256], ey[p]);
      chk("rnd_btn", tk_b[(base + p) % 256], eb[p]);
    end

    // Byte 2 arriving on the last allowed cycle is still accepted.
    base = tick_cnt;
    @(negedge clk); push(8'h1A);
    repeat (100) @(negedge clk);
    push(8'h30);
    @(negedge clk); push(8'h40);
    wait_tick(base + 1, 20);
    chk("edge_x", 32'(xm), 32'h130);
    chk("edge_ym", 32'(ym), 32'h040);

    // Byte 2 one cycle too late: packet dropped, late bytes discarded.
    base = tick_cnt;
    @(negedge clk); push(8'h2D);
    repeat (101) @(negedge clk);
    push(8'h31);
    @(negedge clk); push(8'h42);
    repeat (20) @(negedge clk);
    chk("stall_no_tick", tick_cnt, base);
    chk("stall_xm_kept", 32'(xm), 32'h130);
    packet(8'h2E, 8'h81, 8'h7F);

    // Reset while waiting for byte 2.
    @(negedge clk); push(8'h09);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_rd", 32'(rd_ps2_packet), 32'sd0);
    chk("mid_rst_wr", 32'(wr_ps2), 32'sd0);
    chk("mid_rst_txd", 32'(ps2_tx_data), 32'sd0);
    chk("mid_rst_done", 32'(init_done), 32'sd0);
    chk("mid_rst_xm", 32'(xm), 32'sd0);
    chk("mid_rst_ym", 32'(ym), 32'sd0);
    chk("mid_rst_btn", 32'(btnm), 32'sd0);
    reset = 1'b1;
    pulse_start();
    finish_init();

    // Start during byte 3 with stale bytes queued.
    base = tick_cnt;
    @(negedge clk); push(8'h0B);
    @(negedge clk); push(8'h11);
    @(negedge clk);
    @(negedge clk); push(8'h5C); push(8'hFA); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("start_clears_done", 32'(init_done), 32'sd0);
    finish_init();
    chk("start_no_tick", tick_cnt, base);

    // BAT failure on every attempt.
    base = tx_cnt;
    pulse_start();
    for (int a = 0; a < 3; a++) begin
      wait_tx(base + a + 1, 300);
      chk("fail_ff", 32'(tx_log[(base + a) % 64]), 32'hFF);
      chk("fail_err_pending", 32'(init_err), 32'sd0);
      @(negedge clk); push(8'hFA); push(8'hFC);
    end
    repeat (10) @(negedge clk);
    chk("fail_err", 32'(init_err), 32'sd1);
    chk("fail_done", 32'(init_done), 32'sd0);
    repeat (150) @(negedge clk);
    chk("err_holds_no_tx", tx_cnt, base + 3);
    chk("err_holds", 32'(init_err), 32'sd1);

    // Silence after every reset command.
    base = tx_cnt;
    pulse_start();
    chk("restart_clears_err", 32'(init_err), 32'sd0);
    for (int a = 0; a < 3; a++) begin
      wait_tx(base + a + 1, 400);
      chk("to_ff", 32'(tx_log[(base + a) % 64]), 32'hFF);
    end
    repeat (90) @(negedge clk);
    chk("to_err_not_early", 32'(init_err), 32'sd0);
    repeat (40) @(negedge clk);
    chk("to_err", 32'(init_err), 32'sd1);
    chk("to_done", 32'(init_done), 32'sd0);
    chk("to_tx_count", tx_cnt, base + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
